// File: rtl/cla_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
package cla_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the byte index; never narrower than one bit.
    function automatic int idx_width(input int nbytes);
        return (nbytes <= 2) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/cla_seq_ctrl_adder.sv
// Shared 8-bit carry-look-ahead adder (combinational).
module CarryLookAheadAdder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] gen;
    logic [7:0] prop;
    logic [8:0] carry;
    logic       look;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Each carry is expanded directly from generate/propagate terms and cin.
    always_comb begin
        carry    = '0;
        look     = 1'b0;
        carry[0] = cin;
        for (int i = 0; i < 8; i++) begin
            look = cin;
            for (int k = 0; k <= i; k++) begin
                look = gen[k] | (prop[k] & look);
            end
            carry[i+1] = look;
        end
    end

    assign sum  = prop ^ carry[7:0];
    assign cout = carry[8];

endmodule

// File: rtl/cla_seq_ctrl.sv
// Multi-precision add/subtract sequencer streaming bytes through one shared CLA.
module cla_seq_ctrl
    import cla_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_sub,
    input  logic [BYTE_W*NBYTES-1:0] req_a,
    input  logic [BYTE_W*NBYTES-1:0] req_b,
    input  logic                     req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [BYTE_W*NBYTES-1:0] rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_ovf
);

    localparam int                IDX_W    = idx_width(NBYTES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

    state_t                           state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic                             carry_q, carry_d;
    logic [NBYTES-1:0][BYTE_W-1:0]    a_q, a_d;
    logic [NBYTES-1:0][BYTE_W-1:0]    b_q, b_d;
    logic [NBYTES-1:0][BYTE_W-1:0]    sum_q, sum_d;
    logic                             cout_q, cout_d;
    logic                             ovf_q, ovf_d;

    logic [BYTE_W-1:0]                add_a;
    logic [BYTE_W-1:0]                add_b;
    logic                             add_cin;
    logic [BYTE_W-1:0]                add_sum;
    logic                             add_cout;

    CarryLookAheadAdder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Drive the shared adder only while running; otherwise hold its inputs at zero.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[idx_q];
            add_b   = b_q[idx_q];
            add_cin = carry_q;
        end
    end

    // Next-state logic: accept in IDLE, one byte per clock in RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_sub ? ~req_b : req_b;
                    idx_d   = '0;
                    carry_d = req_sub ? 1'b1 : req_cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = add_sum;
                carry_d      = add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    ovf_d   = (a_q[NBYTES-1][BYTE_W-1] == b_q[NBYTES-1][BYTE_W-1]) &&
                              (add_sum[BYTE_W-1] != a_q[NBYTES-1][BYTE_W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed self-checking bench for the multi-precision add/subtract sequencer.
module tb_cla_seq_ctrl;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_sub;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_cin;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_ovf;

    int checks = 0;
    int errors = 0;

    cla_seq_ctrl #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sub   (req_sub),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request for a single accepting edge, then drop req_valid.
    task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic cin);
        @(negedge clk);
        req_a     = a;
        req_b     = b;
        req_sub   = sub;
        req_cin   = cin;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Count clocks from the accepting edge until rsp_valid, bounded.
    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // Consume the response with a one-clock rsp_ready pulse.
    task automatic consume();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_sub   = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_cout, rsp_ovf} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got rdy/vld/cout/ovf=%b expected 1000",
                     {req_ready, rsp_valid, rsp_cout, rsp_ovf});
        end
        checks++;
        if (rsp_sum !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_sum: got %h expected 00000000", rsp_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_basic();
        int cyc;
        send_req(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_ready: got %b expected 0", req_ready);
        end
        req_a = 32'hDEADBEEF;
        req_b = 32'h12345678;
        wait_rsp(cyc);
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("[TB] FAIL add_latency: got %0d clocks expected 4", cyc);
        end
        checks++;
        if ({rsp_sum, rsp_cout, rsp_ovf} !== {32'h00000100, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL add_basic: got sum=%h cout=%b ovf=%b expected 00000100 0 0",
                     rsp_sum, rsp_cout, rsp_ovf);
        end
        consume();
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL consume_handshake: got vld/rdy=%b expected 01",
                     {rsp_valid, req_ready});
        end
    endtask

    task automatic test_add_ripple();
        int cyc;
        send_req(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1);
        wait_rsp(cyc);
        checks++;
        if ({rsp_sum, rsp_cout, rsp_ovf} !== {32'h00000000, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL add_ripple: got sum=%h cout=%b ovf=%b expected 00000000 1 0",
                     rsp_sum, rsp_cout, rsp_ovf);
        end
        consume();
    endtask

    task automatic test_sub_borrow();
        int cyc;
        send_req(32'h00000005, 32'h00000007, 1'b1, 1'b1);
        wait_rsp(cyc);
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("[TB] FAIL sub_latency: got %0d clocks expected 4", cyc);
        end
        checks++;
        if ({rsp_sum, rsp_cout, rsp_ovf} !== {32'hFFFFFFFE, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL sub_borrow: got sum=%h cout=%b ovf=%b expected FFFFFFFE 0 0",
                     rsp_sum, rsp_cout, rsp_ovf);
        end
        consume();
    endtask

    task automatic test_overflow();
        int cyc;
        send_req(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        wait_rsp(cyc);
        checks++;
        if ({rsp_sum, rsp_cout, rsp_ovf} !== {32'h80000000, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL add_overflow: got sum=%h cout=%b ovf=%b expected 80000000 0 1",
                     rsp_sum, rsp_cout, rsp_ovf);
        end
        consume();
        send_req(32'h80000000, 32'h00000001, 1'b1, 1'b0);
        wait_rsp(cyc);
        checks++;
        if ({rsp_sum, rsp_cout, rsp_ovf} !== {32'h7FFFFFFF, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL sub_overflow: got sum=%h cout=%b ovf=%b expected 7FFFFFFF 1 1",
                     rsp_sum, rsp_cout, rsp_ovf);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int cyc;
        send_req(32'h11111111, 32'h22222222, 1'b0, 1'b0);
        wait_rsp(cyc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_a     = 32'hA5A5A5A5 + 32'(i);
            req_b     = 32'h5A5A5A5A;
            req_sub   = i[0];
            req_cin   = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if ({rsp_valid, req_ready, rsp_sum, rsp_cout, rsp_ovf} !==
                {1'b1, 1'b0, 32'h33333333, 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL backpressure_hold[%0d]: got vld=%b rdy=%b sum=%h cout=%b ovf=%b expected 1 0 33333333 0 0",
                         i, rsp_valid, req_ready, rsp_sum, rsp_cout, rsp_ovf);
            end
        end
        req_valid = 1'b0;
        consume();
        send_req(32'h00000010, 32'h00000020, 1'b0, 1'b0);
        wait_rsp(cyc);
        checks++;
        if ({rsp_sum, rsp_cout, rsp_ovf} !== {32'h00000030, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL after_backpressure: got sum=%h cout=%b ovf=%b expected 00000030 0 0",
                     rsp_sum, rsp_cout, rsp_ovf);
        end
        consume();
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        send_req(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, req_ready, rsp_sum, rsp_cout, rsp_ovf} !==
            {1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_mid_run: got vld=%b rdy=%b sum=%h cout=%b ovf=%b expected 0 1 00000000 0 0",
                     rsp_valid, req_ready, rsp_sum, rsp_cout, rsp_ovf);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL aborted_no_rsp: got vld/rdy=%b expected 01",
                     {rsp_valid, req_ready});
        end
        send_req(32'h01020304, 32'h10203040, 1'b0, 1'b0);
        wait_rsp(cyc);
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("[TB] FAIL post_reset_latency: got %0d clocks expected 4", cyc);
        end
        checks++;
        if ({rsp_sum, rsp_cout, rsp_ovf} !== {32'h11223344, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL post_reset_add: got sum=%h cout=%b ovf=%b expected 11223344 0 0",
                     rsp_sum, rsp_cout, rsp_ovf);
        end
        consume();
    endtask

    // Run every scenario in order, then report.
    initial begin
        $display("[TB] starting cla_seq_ctrl bench");
        test_reset();
        test_add_basic();
        test_add_ripple();
        test_sub_borrow();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_seq_ctrl.md
Name: cla_seq_ctrl

Overview:
Multi-precision add/subtract sequencer built around one shared 8-bit carry-look-ahead adder (CarryLookAheadAdder: a[7:0], b[7:0], cin → sum[7:0], cout).
- Accepts two NBYTES-wide operands through a valid/ready handshake.
- Streams them through the 8-bit adder one byte per clock, LSB byte first, with the carry held in a register between bytes.
- Returns the full-width result, carry-out and signed overflow through a second valid/ready handshake.
- Sits between a requesting datapath/CPU and the shared adder; it is the only driver of the adder inputs.

Parameters:
- NBYTES, 4, number of 8-bit bytes per operand (legal range 2..16); operand width W = 8*NBYTES.

Ports:
- clk, input, 1, single system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, request valid.
- req_ready, output, 1, block can accept a request.
- req_sub, input, 1, 0 = add (a+b+cin), 1 = subtract (a-b, cin ignored).
- req_a, input, W, operand A.
- req_b, input, W, operand B.
- req_cin, input, 1, carry-in for add.
- rsp_valid, output, 1, result valid.
- rsp_ready, input, 1, consumer accepts result.
- rsp_sum, output, W, result.
- rsp_cout, output, 1, final carry-out; in subtract, 1 = no borrow.
- rsp_ovf, output, 1, two's-complement signed overflow.

Behaviour:
- Reset (async on rst_n low): state=IDLE, byte index=0, carry register=0, operand registers=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, rsp_valid=0. req_ready=1 (combinational, state==IDLE).
- States and transitions:
  - IDLE: req_ready=1. On req_valid && req_ready at an edge:
    - latch req_a, latch req_b (stored as ~req_b when req_sub=1), index=0.
    - carry register = req_sub ? 1 : req_cin.
    - clear rsp_sum, rsp_cout and rsp_ovf.
    - go to RUN.
  - RUN: req_ready=0. The adder is driven with byte[index] of A, byte[index] of effective B, and the carry register. Each edge:
    - rsp_sum byte[index] <= adder sum; carry register <= adder cout; index <= index+1.
    - When index==NBYTES-1: rsp_cout <= adder cout; rsp_ovf <= (A msb == effB msb) && (sum msb != A msb); go to DONE.
  - DONE: rsp_valid=1, req_ready=0. On rsp_ready: go to IDLE, rsp_valid=0. rsp_sum, rsp_cout and rsp_ovf hold their values until the next accept.
- Latency: rsp_valid rises exactly NBYTES clocks after the accepting edge. Minimum request-to-request spacing is NBYTES+2 clocks; there is no back-to-back accept from DONE.
- Backpressure: in DONE with rsp_ready=0, all outputs stay frozen indefinitely.
- req_valid outside IDLE is ignored; no queueing, no state corruption.
- Request inputs are sampled only on the accepting edge; later changes have no effect.
- Index arithmetic: width clog2(NBYTES), no wrap past NBYTES-1.
- Carry register is 1 bit; overflow is computed only on the MSB byte.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately: all outputs return to reset values, and no rsp_valid is produced for the aborted request.
- Adder inputs are 0 when the state is not RUN, for power and for deterministic waveforms.

Decomposition:
- Shared package cla_pkg:
  - BYTE_W=8.
  - state enum {IDLE, RUN, DONE}.
  - function for index width (clog2).
- One natural sub-module: the existing CarryLookAheadAdder, instantiated once, unmodified.
- Byte muxing, carry register and FSM stay in cla_seq_ctrl.

Test Plan:
- Add 0x000000FF + 0x00000001, cin=0 → rsp_sum=0x00000100, cout=0, ovf=0; rsp_valid exactly 4 clocks after accept.
- Add 0xFFFFFFFF + 0x00000000, cin=1 → rsp_sum=0x00000000, cout=1, ovf=0 (carry ripples through all 4 bytes).
- Subtract 0x00000005 - 0x00000007 (req_cin=1, ignored) → rsp_sum=0xFFFFFFFE, cout=0 (borrow), ovf=0.
- Add 0x7FFFFFFF + 0x00000001, cin=0 → rsp_sum=0x80000000, cout=0, ovf=1. Subtract 0x80000000 - 0x00000001 → rsp_sum=0x7FFFFFFF, cout=1, ovf=1.
- Backpressure: hold rsp_ready=0 for 5 clocks in DONE while pulsing req_valid with new operands → outputs stable, req_ready=0, second request not accepted; accepted only after return to IDLE.
- Assert rst_n=0 during RUN at index 2 → rsp_valid=0, rsp_sum=0, req_ready=1 immediately. After release, a fresh 0x01020304 + 0x10203040 request yields 0x11223344.
